// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry, raster limits and clear-engine state encoding
// used by the framebuffer arbiter and the VGA sync generator.
package vga_fb_pkg;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 8;
    localparam int H_MAX    = 799;
    localparam int V_MAX    = 524;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer linear address: row*160 + col, built from shifts so no multiplier
// is needed.
module fb_addr_calc
    import vga_fb_pkg::*;
(
    input  logic [6:0]        row,
    input  logic [7:0]        col,
    output logic [ADDR_W-1:0] addr
);
    assign addr = ADDR_W'({row, 7'b0}) + ADDR_W'({row, 5'b0}) + ADDR_W'(col);
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer scheduler: display prefetch beats the clear engine,
// which beats the pixel writer. Also produces the x4-scaled on-screen colour.
module vga_fb_arbiter #(
    parameter int FB_W  = vga_fb_pkg::FB_W,
    parameter int FB_H  = vga_fb_pkg::FB_H,
    parameter int H_MAX = vga_fb_pkg::H_MAX,
    parameter int V_MAX = vga_fb_pkg::V_MAX
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               p_tick,
    input  logic [9:0]                         x,
    input  logic [9:0]                         y,
    input  logic                               video_on,
    output logic [vga_fb_pkg::COLOR_W-1:0]     rgb,
    input  logic                               wr_req,
    input  logic [7:0]                         wr_x,
    input  logic [6:0]                         wr_y,
    input  logic [vga_fb_pkg::COLOR_W-1:0]     wr_data,
    output logic                               wr_ack,
    input  logic                               clr_req,
    input  logic [vga_fb_pkg::COLOR_W-1:0]     clr_color,
    output logic                               clr_busy,
    output logic [vga_fb_pkg::ADDR_W-1:0]      mem_addr,
    output logic                               mem_we,
    output logic [vga_fb_pkg::COLOR_W-1:0]     mem_wdata,
    input  logic [vga_fb_pkg::COLOR_W-1:0]     mem_rdata
);
    import vga_fb_pkg::*;

    clr_state_t          state, state_next;
    logic [6:0]          clr_row;
    logic [7:0]          clr_col;
    logic [COLOR_W-1:0]  clr_color_q;
    logic [ADDR_W-1:0]   addr_q, disp_addr, clr_addr, wr_addr;
    logic [COLOR_W-1:0]  prefetch, pixel;
    logic                fetch_d;
    logic                slot, disp_fetch, clr_grant, clr_last, wr_grant, wr_in_range;
    logic [9:0]          line;
    logic [7:0]          dcol;

    // Fetch one column ahead; the x=798 slot fetches column 0 of the next line.
    always_comb begin
        slot = 1'b0;
        dcol = 8'd0;
        line = y;
        if (p_tick && x[1:0] == 2'b10) begin
            if (x < 10'(4*FB_W - 2)) begin
                slot = 1'b1;
                dcol = x[9:2] + 8'd1;
            end else if (x == 10'(H_MAX - 1)) begin
                slot = 1'b1;
                line = (y == 10'(V_MAX)) ? 10'd0 : y + 10'd1;
            end
        end
    end

    assign disp_fetch  = !reset && slot && (line < 10'(4*FB_H));
    assign clr_grant   = !reset && (state == CLR_RUN) && !disp_fetch;
    assign clr_last    = (clr_row == 7'(FB_H - 1)) && (clr_col == 8'(FB_W - 1));
    assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
    // A clear request in the same cycle wins; the writer waits for it to finish.
    assign wr_grant    = !reset && wr_req && (state == CLR_IDLE) && !clr_req && !disp_fetch;
    assign wr_ack      = wr_grant;
    assign clr_busy    = (state == CLR_RUN);
    assign rgb         = video_on ? pixel : '0;

    fb_addr_calc u_disp_addr (.row(line[8:2]), .col(dcol),    .addr(disp_addr));
    fb_addr_calc u_clr_addr  (.row(clr_row),   .col(clr_col), .addr(clr_addr));
    fb_addr_calc u_wr_addr   (.row(wr_y),      .col(wr_x),    .addr(wr_addr));

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = addr_q;
        if (disp_fetch) begin
            mem_addr = disp_addr;
        end else if (clr_grant) begin
            mem_addr  = clr_addr;
            mem_we    = 1'b1;
            mem_wdata = clr_color_q;
        end else if (wr_grant && wr_in_range) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLR_IDLE: if (clr_req)               state_next = CLR_RUN;
            CLR_RUN:  if (clr_grant && clr_last) state_next = CLR_IDLE;
            default:                             state_next = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= CLR_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_row     <= '0;
            clr_col     <= '0;
            clr_color_q <= '0;
            addr_q      <= '0;
            fetch_d     <= 1'b0;
            prefetch    <= '0;
            pixel       <= '0;
        end else begin
            addr_q  <= mem_addr;
            fetch_d <= disp_fetch;
            if (fetch_d)
                prefetch <= mem_rdata;
            if (p_tick && x[1:0] == 2'b11)
                pixel <= prefetch;
            if (state == CLR_IDLE && clr_req) begin
                clr_row     <= '0;
                clr_col     <= '0;
                clr_color_q <= clr_color;
            end else if (clr_grant) begin
                if (clr_col == 8'(FB_W - 1)) begin
                    clr_col <= '0;
                    clr_row <= clr_last ? 7'd0 : clr_row + 7'd1;
                end else begin
                    clr_col <= clr_col + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: drives a raster, a RAM model and
// randomized writer/clear traffic, checking against rules computed here.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        reset, p_tick, video_on, wr_req, clr_req;
    logic [9:0]  x, y;
    logic [7:0]  wr_x, wr_data, clr_color, mem_rdata, rgb, mem_wdata;
    logic [6:0]  wr_y;
    logic        wr_ack, clr_busy, mem_we;
    logic [14:0] mem_addr;

    logic [7:0]  ram [0:19199];
    bit          do_preload = 0;
    bit          run = 0;
    int          checks = 0;
    int          errors = 0;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y), .video_on(video_on),
        .rgb(rgb), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ack(wr_ack), .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 19200; i++) ram[i] <= 8'($urandom);
        end else begin
            if (mem_we && mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
            mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : 8'h00;
        end
    end

    // Expected display fetch for the current raster input, from the slot rules.
    function automatic bit fetch_of(input int xx, input int yy, input bit pt, output int addr);
        int col, ln;
        bit s;
        s = 0; col = 0; ln = 0; addr = 0;
        if (pt && (xx % 4) == 2) begin
            if (xx < 638) begin s = 1; col = xx / 4 + 1; ln = yy; end
            else if (xx == 798) begin s = 1; col = 0; ln = (yy == 524) ? 0 : yy + 1; end
        end
        if (s && ln < 480) begin
            addr = (ln / 4) * 160 + col;
            return 1;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (run) begin
            if (p_tick) begin
                if (x == 10'd799) begin x = 0; y = (y == 10'd524) ? 10'd0 : y + 10'd1; end
                else x = x + 10'd1;
            end
            p_tick = ~p_tick;
        end else begin
            p_tick = 1'b0;
        end
        video_on = (x < 10'd640) && (y < 10'd480);
    endtask

    task automatic set_pos(input int xx, input int yy);
        x = 10'(xx); y = 10'(yy); p_tick = 1'b0;
        video_on = (x < 10'd640) && (y < 10'd480);
    endtask

    task automatic test_reset();
        reset = 1; run = 0; set_pos(0, 0);
        wr_req = 0; wr_x = 0; wr_y = 0; wr_data = 0; clr_req = 0; clr_color = 0;
        tick(); tick(); #1;
        checks++; if (rgb !== 8'h00)       begin errors++; $display("FAIL reset_rgb: got %0h expected 0", rgb); end
        checks++; if (wr_ack !== 1'b0)     begin errors++; $display("FAIL reset_wr_ack: got %0b expected 0", wr_ack); end
        checks++; if (clr_busy !== 1'b0)   begin errors++; $display("FAIL reset_clr_busy: got %0b expected 0", clr_busy); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
        checks++; if (mem_addr !== 15'd0)  begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
        reset = 0;
        tick();
    endtask

    task automatic test_writer();
        int a; bit inr;
        set_pos(0, 490); run = 1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 0)      begin wr_x = 3;   wr_y = 2; wr_data = 8'hA5; end
            else if (i == 1) begin wr_x = 160; wr_y = 0; wr_data = 8'h3C; end
            else begin
                wr_x = 8'($urandom_range(0, 175)); wr_y = 7'($urandom_range(0, 127));
                wr_data = 8'($urandom);
            end
            wr_req = 1; #1;
            inr = (wr_x < 160) && (wr_y < 120);
            a = int'(wr_y) * 160 + int'(wr_x);
            checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL writer_ack: got %0b expected 1 (x=%0d y=%0d)", wr_ack, wr_x, wr_y); end
            checks++; if (mem_we !== inr)  begin errors++; $display("FAIL writer_we: got %0b expected %0b (x=%0d y=%0d)", mem_we, inr, wr_x, wr_y); end
            if (inr) begin
                checks++;
                if (mem_addr !== 15'(a) || mem_wdata !== wr_data) begin
                    errors++; $display("FAIL writer_port: got addr %0d data %0h expected addr %0d data %0h", mem_addr, mem_wdata, a, wr_data);
                end
            end
            if (i == 0) begin
                checks++; if (mem_addr !== 15'd323) begin errors++; $display("FAIL writer_basic_addr: got %0d expected 323", mem_addr); end
            end
            tick(); wr_req = 0; #1;
            checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL writer_ack_drop: got %0b expected 0", wr_ack); end
            if (inr) begin
                checks++; if (ram[a] !== wr_data) begin errors++; $display("FAIL writer_ram: got %0h expected %0h at %0d", ram[a], wr_data, a); end
            end
        end
    endtask

    task automatic run_display(input int sx, input int sy, input int ex, input int ey, input string tag);
        int fa, cyc, exp_rgb; bit f;
        set_pos(sx, sy); run = 1; cyc = 0;
        while (!(x == 10'(ex) && y == 10'(ey)) && cyc < 3000) begin
            tick(); cyc++; #1;
            f = fetch_of(x, y, p_tick, fa);
            if (f) begin
                checks++;
                if (mem_addr !== 15'(fa) || mem_we !== 1'b0) begin
                    errors++; $display("FAIL %s_fetch: got addr %0d we %0b expected addr %0d we 0 (x=%0d y=%0d)", tag, mem_addr, mem_we, fa, x, y);
                end
            end
            if (p_tick && x == 10'd798 && (y == 10'd7 || y == 10'd524)) begin
                checks++;
                if (mem_addr !== ((y == 10'd7) ? 15'd320 : 15'd0)) begin
                    errors++; $display("FAIL %s_left_edge: got %0d at y=%0d", tag, mem_addr, y);
                end
            end
            exp_rgb = video_on ? int'(ram[(int'(y) / 4) * 160 + int'(x) / 4]) : 0;
            if (y == 10'(ey) || !video_on) begin
                checks++;
                if (rgb !== 8'(exp_rgb)) begin
                    errors++; $display("FAIL %s_rgb: got %0h expected %0h (x=%0d y=%0d)", tag, rgb, exp_rgb, x, y);
                end
            end
        end
        if (cyc >= 3000) begin errors++; $display("FAIL %s_timeout: got %0d cycles expected under 3000", tag, cyc); end
    endtask

    task automatic test_display();
        do_preload = 1; tick(); do_preload = 0;
        run_display(780, 7, 700, 8, "display");
    endtask

    task automatic test_wrap();
        run_display(790, 524, 40, 0, "wrap");
    endtask

    task automatic test_contention();
        int fa, wa, cyc; bit f, d;
        for (int i = 0; i < 6; i++) begin
            wr_req = 0;
            set_pos($urandom_range(0, 600), $urandom_range(0, 470)); run = 1;
            f = 0; cyc = 0;
            while (!f && cyc < 20) begin tick(); cyc++; #1; f = fetch_of(x, y, p_tick, fa); end
            if (!f) begin errors++; $display("FAIL contention_timeout: got no slot expected one"); continue; end
            wr_x = 8'($urandom_range(0, 159)); wr_y = 7'($urandom_range(0, 119)); wr_data = 8'($urandom);
            wa = int'(wr_y) * 160 + int'(wr_x);
            wr_req = 1; #1;
            checks++;
            if (wr_ack !== 1'b0 || mem_addr !== 15'(fa) || mem_we !== 1'b0) begin
                errors++; $display("FAIL contention_slot: got ack %0b addr %0d we %0b expected ack 0 addr %0d we 0", wr_ack, mem_addr, mem_we, fa);
            end
            tick(); #1;
            d = fetch_of(x, y, p_tick, fa);
            checks++;
            if (wr_ack !== !d || (!d && (mem_addr !== 15'(wa) || mem_we !== 1'b1))) begin
                errors++; $display("FAIL contention_next: got ack %0b addr %0d expected ack %0b addr %0d", wr_ack, mem_addr, !d, wa);
            end
            tick(); wr_req = 0;
        end
    endtask

    task automatic test_clear();
        int fa, clr_exp, cyc, bad; bit f, ack_seen;
        set_pos(0, 470); run = 1; tick();
        clr_req = 1; clr_color = 8'h1C;
        wr_req = 1; wr_x = 5; wr_y = 5; wr_data = 8'h77; #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL clear_start_ack: got %0b expected 0", wr_ack); end
        clr_exp = 0; cyc = 0;
        while (clr_exp < 19200 && cyc < 30000) begin
            tick(); cyc++;
            clr_req = (clr_exp == 5000);
            clr_color = clr_req ? 8'h55 : 8'h1C;
            #1;
            f = fetch_of(x, y, p_tick, fa);
            checks++;
            if (f) begin
                if (mem_addr !== 15'(fa) || mem_we !== 1'b0 || wr_ack !== 1'b0 || clr_busy !== 1'b1) begin
                    errors++; $display("FAIL clear_fetch: got addr %0d we %0b ack %0b busy %0b expected addr %0d we 0 ack 0 busy 1", mem_addr, mem_we, wr_ack, clr_busy, fa);
                end
            end else begin
                if (mem_we !== 1'b1 || mem_addr !== 15'(clr_exp) || mem_wdata !== 8'h1C || wr_ack !== 1'b0 || clr_busy !== 1'b1) begin
                    errors++; $display("FAIL clear_write: got addr %0d we %0b data %0h ack %0b busy %0b expected addr %0d we 1 data 1c", mem_addr, mem_we, mem_wdata, wr_ack, clr_busy, clr_exp);
                end
                clr_exp++;
            end
        end
        clr_req = 0;
        if (cyc >= 30000) begin errors++; $display("FAIL clear_timeout: got %0d writes expected 19200", clr_exp); end
        ack_seen = 0;
        for (int k = 0; k < 4 && !ack_seen; k++) begin
            tick(); #1;
            f = fetch_of(x, y, p_tick, fa);
            checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_busy_fall: got %0b expected 0", clr_busy); end
            checks++; if (wr_ack !== !f)     begin errors++; $display("FAIL clear_wr_ack: got %0b expected %0b", wr_ack, !f); end
            if (!f) begin
                ack_seen = 1;
                checks++;
                if (mem_addr !== 15'd805 || mem_we !== 1'b1 || mem_wdata !== 8'h77) begin
                    errors++; $display("FAIL clear_wr_port: got addr %0d we %0b data %0h expected 805 1 77", mem_addr, mem_we, mem_wdata);
                end
            end
        end
        tick(); wr_req = 0;
        bad = 0;
        for (int i = 0; i < 19200; i++) if (ram[i] !== ((i == 805) ? 8'h77 : 8'h1C)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_ram: got %0d wrong cells expected 0", bad); end
    endtask

    task automatic test_reset_mid_clear();
        set_pos(0, 200); run = 1; tick();
        clr_req = 1; clr_color = 8'hE3; tick(); clr_req = 0;
        repeat (100) tick();
        #1;
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL midclr_busy: got %0b expected 1", clr_busy); end
        reset = 1;
        tick(); #1;
        checks++; if (clr_busy !== 1'b0)   begin errors++; $display("FAIL midclr_reset_busy: got %0b expected 0", clr_busy); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL midclr_reset_we: got %0b expected 0", mem_we); end
        checks++; if (mem_addr !== 15'd0)  begin errors++; $display("FAIL midclr_reset_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL midclr_reset_wdata: got %0h expected 0", mem_wdata); end
        checks++; if (wr_ack !== 1'b0)     begin errors++; $display("FAIL midclr_reset_ack: got %0b expected 0", wr_ack); end
        checks++; if (rgb !== 8'h00)       begin errors++; $display("FAIL midclr_reset_rgb: got %0h expected 0", rgb); end
        reset = 0;
        tick(); tick(); #1;
        checks++; if (clr_busy !== 1'b0)   begin errors++; $display("FAIL midclr_stays_idle: got %0b expected 0", clr_busy); end
    endtask

    initial begin
        test_reset();
        test_writer();
        test_display();
        test_wrap();
        test_contention();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
